// File: rtl/rgbled_sequencer.sv
// rgbled_sequencer: plays a host-written step table of r/g/b speeds and durations into the RGB cycle block.
module rgbled_sequencer #(
  parameter int DEPTH = 8,
  parameter int DUR_W = 16,
  parameter int TICK_DIV = 12000,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [15+DUR_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]   last_idx,
  input  logic                loop_en,
  input  logic                start,
  input  logic                stop,
  output logic [4:0]          r_speed,
  output logic [4:0]          g_speed,
  output logic [4:0]          b_speed,
  output logic                cycle_en,
  output logic                busy,
  output logic [ADDR_W-1:0]   step_idx,
  output logic                done
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state, state_nxt;
  logic [15+DUR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [DUR_W-1:0] cnt;
  logic [PW-1:0] pre;
  logic first, tick, adv, at_last;
  assign tick = state == RUN && pre == PW'(TICK_DIV - 1);
  assign adv = tick && cnt == DUR_W'(1);
  assign at_last = idx == last_idx;
  assign step_idx = idx;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    idx_nxt = idx;
    if (stop) begin
      state_nxt = IDLE;
      idx_nxt = '0;
    end else if (start) begin
      state_nxt = LOAD;
      idx_nxt = '0;
    end else if (state == LOAD) begin
      state_nxt = RUN;
    end else if (adv) begin
      state_nxt = (at_last && !loop_en) ? IDLE : LOAD;
      idx_nxt = at_last ? '0 : idx + 1'b1;
    end
  end
  always_comb begin
    busy = state != IDLE;
    cycle_en = state == RUN || (state == LOAD && !first);
    done = adv && !stop && !start && at_last && !loop_en;
  end
  // Table has no reset so contents survive rst; a LOAD reads the pre-write value on a same-cycle write.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      cnt <= '0;
      pre <= '0;
      first <= 1'b0;
      {b_speed, g_speed, r_speed} <= '0;
    end else begin
      idx <= idx_nxt;
      pre <= (state == RUN && !tick) ? pre + 1'b1 : '0;
      first <= state == IDLE || (state == LOAD && first);
      if (state_nxt == IDLE) begin
        cnt <= '0;
        {b_speed, g_speed, r_speed} <= '0;
      end else if (state == LOAD) begin
        {cnt, b_speed, g_speed, r_speed} <= mem[idx];
      end else if (tick && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
endmodule

// File: doc/rgbled_sequencer.md
Name: rgbled_sequencer

Overview:
Step-table sequencer that drives the speed inputs and enable of the RGB cycle block.
- Host side (SPI register bridge) writes up to DEPTH steps. Each step holds an r/g/b speed triple and a duration in ticks.
- The sequencer plays the steps in order, one-shot or looping, and gates the cycle block via cycle_en.
- Sits between the SPI register file and the RGB cycle instance.

Parameters:
DEPTH, 8, number of step entries; must be a power of two; ADDR_W = clog2(DEPTH).
DUR_W, 16, width of step duration field (ticks).
TICK_DIV, 12000, clk cycles per tick (1 ms at 12 MHz); must be >= 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
wr_en  in  1  table write strobe; one write per asserted cycle
wr_addr  in  ADDR_W  step index to write
wr_data  in  15+DUR_W  {dur[DUR_W-1:0], b[4:0], g[4:0], r[4:0]}
last_idx  in  ADDR_W  index of final step in sequence
loop_en  in  1  1 = wrap to step 0 after last_idx; 0 = stop after last_idx
start  in  1  single-cycle pulse; (re)start playback at step 0
stop  in  1  single-cycle pulse; abort playback
r_speed  out  5  red speed to cycle block
g_speed  out  5  green speed to cycle block
b_speed  out  5  blue speed to cycle block
cycle_en  out  1  enable to cycle block
busy  out  1  high in LOAD or RUN
step_idx  out  ADDR_W  index of current/next step
done  out  1  one-cycle pulse when a non-looping sequence completes

Behaviour:
- Reset (async, rst=1): state IDLE. r/g/b_speed=0, cycle_en=0, busy=0, step_idx=0, done=0, prescaler=0, duration counter=0. Table contents are not reset (undefined until written).
- Table writes: synchronous, wr_en=1 writes wr_data to entry wr_addr.
  - Writes are accepted in every state.
  - A write to the step currently playing has no effect until that step is next LOADed.
- States: IDLE, LOAD, RUN.
- IDLE:
  - Outputs hold the reset values: speeds 0, cycle_en 0.
  - start=1 -> LOAD, step_idx=0.
- LOAD (exactly 1 cycle):
  - Reads table[step_idx] and registers speeds plus duration counter at the end of the cycle.
  - Clears the prescaler.
  - Goes to RUN.
  - cycle_en=1 during LOAD except on the first LOAD after IDLE, where it is 0.
- RUN:
  - cycle_en=1 and speeds are stable.
  - Prescaler counts 0..TICK_DIV-1. tick = (prescaler == TICK_DIV-1), then the prescaler wraps to 0.
  - dur=0: hold the step indefinitely; no advance; only stop or start leave it.
  - dur=D>=1: on each tick the counter decrements. The tick that takes it from 1 to 0 advances, so RUN lasts exactly D*TICK_DIV cycles.
  - Advance when step_idx != last_idx: step_idx+1 -> LOAD.
  - Advance when step_idx == last_idx and loop_en=1: step_idx=0 -> LOAD.
  - Advance when step_idx == last_idx and loop_en=0: done=1 for one cycle, step_idx=0 -> IDLE. Speeds and cycle_en are 0 from the next cycle.
- Timing:
  - Latency: start sampled at cycle N -> LOAD at N+1 -> new speeds and cycle_en=1 visible at N+2.
  - Step-to-step period is D*TICK_DIV + 1 cycles.
- Priority (same cycle): stop > start > advance.
  - stop in any state -> IDLE next cycle with outputs cleared; done is not asserted.
  - start while busy -> LOAD with step_idx=0 (restart); any pending advance is discarded.
- Sampling: loop_en and last_idx are sampled only at the advance decision. Changing them mid-sequence affects the next decision only.
- Reset mid-operation: returns to IDLE immediately (async); table is retained.
- Arithmetic: step_idx increments modulo DEPTH (it cannot exceed last_idx under normal flow). No other overflow cases exist.

Test Plan:
1. Reset/idle: assert rst mid-RUN -> same cycle speeds=0, cycle_en=0, busy=0; after release, start plays step 0 from table contents written before reset.
2. One-shot timing (TICK_DIV=4): write step0={r=3,g=5,b=7,dur=2}, step1={r=11,g=13,b=17,dur=1}, last_idx=1, loop_en=0; start at cycle 0.
   - Speeds 3/5/7 and cycle_en=1 at cycle 2.
   - LOAD at cycle 10; 11/13/17 at cycle 11.
   - done pulse at cycle 14; outputs 0 at cycle 15.
3. Looping: same table with loop_en=1 -> after step1 returns to step0 (LOAD, speeds 3/5/7). done never asserts over 3 loops; cycle_en stays 1 throughout.
4. Hold step: step0 dur=0, start -> speeds stay constant for >1000 cycles. stop -> IDLE next cycle, done=0.
5. Priority: stop and start asserted together in RUN -> IDLE. start alone at step1 -> LOAD with step_idx=0 next cycle.
6. Live write: during RUN of step0, write step0={r=31,g=0,b=0,dur=1} -> current speeds unchanged; new values appear on the next loop's step0.
